vred_64: RTL

Sequential horizontal byte-lane reducer for the vector datapath. It is the inverse of the splat/broadcast stage: that stage replicates one scalar byte across lanes, while this block collapses the eight byte lanes of a 64-bit vector (`VX_hi`, `VX_lo`) back into one 32-bit scalar. Supported operations are sum, max, min and single-lane extract. One lane is processed per cycle, with a start/busy/done handshake toward the control unit.

---
 rtl/vred_64.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/vred_64.sv
// vred_64: sequential horizontal byte-lane reducer (sum / max / min / extract).
// Collapses the byte lanes of {VX_hi, VX_lo} into one 32-bit scalar, one lane
// per clock, with a start/busy/done handshake.
// Optional feature macro: VRED_SIGNED_EN (two's-complement lanes when SGN=1).
// Handshake: start is sampled only in IDLE; busy is high in RUN and DONE;
// done is a one-cycle pulse during which Y/IDX are valid, and Y/IDX then hold
// until the next accepted operation reaches DONE.
module vred_64 #(
    parameter int LANES = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  OP,
    input  logic [2:0]  SEL,
    input  logic        SGN,
    input  logic [31:0] VX_hi,
    input  logic [31:0] VX_lo,
    output logic [31:0] Y,
    output logic [2:0]  IDX,
    output logic        busy,
    output logic        done,
    output logic [1:0]  dbg_state
);

`ifdef VRED_SIGNED_EN
    localparam logic SIGNED_EN = 1'b1;
`else
    localparam logic SIGNED_EN = 1'b0;
`endif

    localparam logic [2:0] LAST = 3'(LANES - 1);

    localparam logic [1:0] OP_SUM = 2'b00;
    localparam logic [1:0] OP_MAX = 2'b01;
    localparam logic [1:0] OP_MIN = 2'b10;
    localparam logic [1:0] OP_EXT = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    // Operands captured at start; later input changes are ignored.
    logic [1:0]  op_r;
    logic [2:0]  sel_r;
    logic        sgn_r;
    logic [63:0] vec_r;

    logic [2:0]  cnt;
    logic [10:0] acc;
    logic [2:0]  idx_r;

    logic        sgn_eff;
    logic        sgn_in_eff;
    logic [7:0]  lane_raw;
    logic [10:0] lane_ext;
    logic [10:0] lane0_ext;
    logic [10:0] acc_next;
    logic [2:0]  idx_next;
    logic [31:0] res_y;

    // SGN only matters when the signed feature is built in.
    assign sgn_eff    = sgn_r & SIGNED_EN;
    assign sgn_in_eff = SGN & SIGNED_EN;

    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign dbg_state = state;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = S_RUN;
            S_RUN:   if (cnt == LAST) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Current lane, widened to the 11-bit accumulator width.
    always_comb begin
        lane_raw  = vec_r[{cnt, 3'b000} +: 8];
        lane_ext  = sgn_eff ? {{3{lane_raw[7]}}, lane_raw} : {3'b000, lane_raw};
        lane0_ext = sgn_in_eff ? {{3{VX_lo[7]}}, VX_lo[7:0]} : {3'b000, VX_lo[7:0]};
    end

    // One reduction step; comparisons are strict so ties keep the lowest lane.
    always_comb begin
        acc_next = acc;
        idx_next = idx_r;
        case (op_r)
            OP_SUM: begin
                acc_next = acc + lane_ext;
                idx_next = 3'd0;
            end
            OP_MAX: begin
                if ($signed(lane_ext) > $signed(acc)) begin
                    acc_next = lane_ext;
                    idx_next = cnt;
                end
            end
            OP_MIN: begin
                if ($signed(lane_ext) < $signed(acc)) begin
                    acc_next = lane_ext;
                    idx_next = cnt;
                end
            end
            default: begin
                if (cnt == sel_r) acc_next = lane_ext;
                idx_next = sel_r;
            end
        endcase
    end

    // Final scalar: extend the 11-bit accumulator; an out-of-range extract is 0.
    always_comb begin
        res_y = sgn_eff ? {{21{acc_next[10]}}, acc_next} : {21'd0, acc_next};
        if ((op_r == OP_EXT) && (sel_r > LAST)) res_y = 32'd0;
    end

    // Capture, per-lane accumulation and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_r  <= 2'd0;
            sel_r <= 3'd0;
            sgn_r <= 1'b0;
            vec_r <= 64'd0;
            cnt   <= 3'd0;
            acc   <= 11'd0;
            idx_r <= 3'd0;
            Y     <= 32'd0;
            IDX   <= 3'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_r  <= OP;
                        sel_r <= SEL;
                        sgn_r <= SGN;
                        vec_r <= {VX_hi, VX_lo};
                        cnt   <= 3'd0;
                        acc   <= (OP == OP_SUM) ? 11'd0 : lane0_ext;
                        idx_r <= 3'd0;
                    end
                end
                S_RUN: begin
                    acc   <= acc_next;
                    idx_r <= idx_next;
                    cnt   <= cnt + 3'd1;
                    if (cnt == LAST) begin
                        Y   <= res_y;
                        IDX <= idx_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
